// File: rtl/vga_pkg.sv
// vga_pkg -- default 640x480@60 timing shared by the sync generator and the
// downstream graphics stage: raw porch/sync widths, frame totals, sync windows
// and the position counter type.
package vga_pkg;

    // Position counter width; 10 bits covers totals up to 1023.
    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] pix_cnt_t;

    // Horizontal timing in pixels.
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    // Vertical timing in lines.
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Derived totals and sync windows (first/last position with sync low).
    localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // True when pos lies in the inclusive window [first, last].
    function automatic logic in_window(input pix_cnt_t pos,
                                       input pix_cnt_t first,
                                       input pix_cnt_t last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// vga_tick_gen -- pixel-enable divider. Counts 0..CLK_DIV-1 on every clk and
// raises tick while the count sits at its last value, so tick is a one-clk
// strobe every CLK_DIV clocks (constantly high when CLK_DIV is 1).
module vga_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // With CLK_DIV=1 a single always-zero bit is kept so the tick compare
    // still holds and the code needs no special case.
    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] L_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    // Divider count: wraps from CLK_DIV-1 back to 0.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == L_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == L_LAST);

endmodule

// File: rtl/vga_sync.sv
// vga_sync -- VGA raster timing generator. Produces the pixel strobe, the
// current (pix_x, pix_y) position, video_on and active-low hsync/vsync.
// Optional build macro VGA_FRAME_TICK_EN adds a one-clk frame_tick output on
// the pixel strobe that finishes the last position of a frame.
module vga_sync
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic             frame_tick
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam pix_cnt_t L_H_LAST     = pix_cnt_t'(H_TOTAL - 1);
    localparam pix_cnt_t L_V_LAST     = pix_cnt_t'(V_TOTAL - 1);
    localparam pix_cnt_t L_H_DISP     = pix_cnt_t'(H_DISPLAY);
    localparam pix_cnt_t L_V_DISP     = pix_cnt_t'(V_DISPLAY);
    localparam pix_cnt_t L_HS_FIRST   = pix_cnt_t'(H_DISPLAY + H_FRONT);
    localparam pix_cnt_t L_HS_LAST    = pix_cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam pix_cnt_t L_VS_FIRST   = pix_cnt_t'(V_DISPLAY + V_FRONT);
    localparam pix_cnt_t L_VS_LAST    = pix_cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic     w_p_tick;
    logic     w_h_end;
    logic     w_v_end;
    pix_cnt_t w_h_next;
    pix_cnt_t w_v_next;

    pix_cnt_t r_h_count;
    pix_cnt_t r_v_count;
    logic     r_hsync;
    logic     r_vsync;

    vga_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_p_tick)
    );

    assign w_h_end = (r_h_count == L_H_LAST);
    assign w_v_end = (r_v_count == L_V_LAST);

    // Next position: advances only on a pixel strobe; end of line bumps the
    // line count, end of line on the last line wraps the whole frame.
    // NOTE: hold values are assigned first so every path drives both outputs
    // and no latch is inferred.
    always_comb begin
        w_h_next = r_h_count;
        w_v_next = r_v_count;
        if (w_p_tick) begin
            if (w_h_end) begin
                w_h_next = '0;
                w_v_next = w_v_end ? '0 : r_v_count + 1'b1;
            end else begin
                w_h_next = r_h_count + 1'b1;
            end
        end
    end

    // Position and sync registers; syncs decode the next position so they
    // change on the same edge as the counts they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
        end else begin
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
            r_hsync   <= ~in_window(w_h_next, L_HS_FIRST, L_HS_LAST);
            r_vsync   <= ~in_window(w_v_next, L_VS_FIRST, L_VS_LAST);
        end
    end

    assign p_tick   = w_p_tick;
    assign pix_x    = r_h_count;
    assign pix_y    = r_v_count;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = (r_h_count < L_H_DISP) && (r_v_count < L_V_DISP);

`ifdef VGA_FRAME_TICK_EN
    assign frame_tick = w_p_tick & w_h_end & w_v_end;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync -- randomized scoreboard bench for vga_sync. Two instances with
// reduced timing (CLK_DIV=3 and CLK_DIV=1) share clock and reset. The stimulus
// process runs random-length stretches, asserts reset asynchronously between
// edges, and pushes the expected outputs of both instances into a queue; a
// monitor pops and compares. Expected values come from an arithmetic model:
// after n clock edges since reset release, floor(n/CLK_DIV) pixels have
// elapsed, and the position is that count taken modulo the frame size.
module tb_vga_sync;

    localparam int DIV_A  = 3;
    localparam int HD     = 16;
    localparam int HF     = 4;
    localparam int H_SYN  = 6;
    localparam int HB     = 6;
    localparam int VD     = 12;
    localparam int VF     = 2;
    localparam int V_SYN  = 2;
    localparam int VB     = 3;
    localparam int HT     = HD + HF + H_SYN + HB;
    localparam int VT     = VD + VF + V_SYN + VB;
    localparam int FRAME_CLKS_A = HT * VT * DIV_A;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_hsync, a_vsync, a_video_on, a_p_tick;
    logic [9:0] a_pix_x, a_pix_y;
    logic       b_hsync, b_vsync, b_video_on, b_p_tick;
    logic [9:0] b_pix_x, b_pix_y;
`ifdef VGA_FRAME_TICK_EN
    logic       a_frame_tick, b_frame_tick;
`endif

    always #5 clk = ~clk;

    vga_sync #(
        .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(H_SYN), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(V_SYN), .V_BACK(VB)
    ) dut_a (
        .clk(clk), .reset(reset), .hsync(a_hsync), .vsync(a_vsync),
        .video_on(a_video_on), .p_tick(a_p_tick), .pix_x(a_pix_x), .pix_y(a_pix_y)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(a_frame_tick)
`endif
    );

    vga_sync #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(H_SYN), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(V_SYN), .V_BACK(VB)
    ) dut_b (
        .clk(clk), .reset(reset), .hsync(b_hsync), .vsync(b_vsync),
        .video_on(b_video_on), .p_tick(b_p_tick), .pix_x(b_pix_x), .pix_y(b_pix_y)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(b_frame_tick)
`endif
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       tick;
        logic       ft;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
    } item_t;

    item_t q[$];
    event  e_sample;
    int    n_clks = 0;
    int    errors = 0;
    int    checks = 0;
    bit    stim_done = 1'b0;

    // Expected outputs after 'clks' edges since reset release.
    function automatic exp_t model(input int clks, input int div);
        exp_t e;
        int   p;
        int   x;
        int   y;
        p      = (clks / div) % (HT * VT);
        x      = p % HT;
        y      = p / HT;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.tick = ((clks % div) == div - 1);
        e.hs   = !((x >= HD + HF) && (x < HD + HF + H_SYN));
        e.vs   = !((y >= VD + VF) && (y < VD + VF + V_SYN));
        e.von  = (x < HD) && (y < VD);
        e.ft   = e.tick && (x == HT - 1) && (y == VT - 1);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, clks=%0d)", name, act, exp, $time, n_clks);
        end
    endtask

    // Push the expected response for the current state and signal the monitor.
    task automatic push_expect();
        item_t it;
        it.a = model(n_clks, DIV_A);
        it.b = model(n_clks, 1);
        q.push_back(it);
        #1 -> e_sample;
    endtask

    // Each step: one rising edge, then expected values sampled mid-low-phase.
    task automatic run_clks(input int k);
        repeat (k) begin
            @(posedge clk);
            n_clks++;
            @(negedge clk);
            push_expect();
        end
    endtask

    // Called right after a push (negedge+1): reset lands between edges and
    // outputs are sampled before the next rising edge.
    task automatic assert_reset();
        #1 reset = 1'b1;
        n_clks = 0;
        push_expect();
        repeat (2) begin
            @(negedge clk);
            push_expect();
        end
    endtask

    task automatic release_reset();
        #1 reset = 1'b0;
        n_clks = 0;
    endtask

    // Monitor: compares every queued expectation against live DUT outputs.
    initial begin
        item_t it;
        forever begin
            @(e_sample);
            while (q.size() > 0) begin
                it = q.pop_front();
                check("a.pix_x",    32'(a_pix_x),    32'(it.a.x));
                check("a.pix_y",    32'(a_pix_y),    32'(it.a.y));
                check("a.hsync",    32'(a_hsync),    32'(it.a.hs));
                check("a.vsync",    32'(a_vsync),    32'(it.a.vs));
                check("a.video_on", 32'(a_video_on), 32'(it.a.von));
                check("a.p_tick",   32'(a_p_tick),   32'(it.a.tick));
                check("b.pix_x",    32'(b_pix_x),    32'(it.b.x));
                check("b.pix_y",    32'(b_pix_y),    32'(it.b.y));
                check("b.hsync",    32'(b_hsync),    32'(it.b.hs));
                check("b.vsync",    32'(b_vsync),    32'(it.b.vs));
                check("b.video_on", 32'(b_video_on), 32'(it.b.von));
                check("b.p_tick",   32'(b_p_tick),   32'(it.b.tick));
`ifdef VGA_FRAME_TICK_EN
                check("a.frame_tick", 32'(a_frame_tick), 32'(it.a.ft));
                check("b.frame_tick", 32'(b_frame_tick), 32'(it.b.ft));
`endif
            end
        end
    end

    // Stimulus: reset state, two full frames, random runs cut by async reset.
    initial begin
        reset  = 1'b1;
        n_clks = 0;
        repeat (2) begin
            @(negedge clk);
            push_expect();
        end
        release_reset();
        run_clks(2 * FRAME_CLKS_A + 40);
        for (int i = 0; i < 4; i++) begin
            run_clks(int'($urandom_range(50, 2000)));
            assert_reset();
            release_reset();
        end
        run_clks(FRAME_CLKS_A + 60);
        @(negedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 32'd0);
        stim_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #2000000;
        if (!stim_done) begin
            $display("FAIL watchdog: stimulus not finished, got t=%0t expected completion", $time);
            $fatal(1, "watchdog expired");
        end
    end

endmodule
